// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared pipeline constants for the writeback arbiter.
// Register address width, x0 encoding and default data width.
package regfile_wr_arbiter_pkg;
  localparam int REG_ADDR_W     = 5;
  localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int AGE_W          = 4;
  localparam logic [AGE_W-1:0] AGE_MAX = 4'd15;
  localparam logic [1:0] FIFO_DEPTH = 2'd2;
endpackage

// File: rtl/regfile_wr_arbiter_wb_skid_fifo.sv
// Two-entry queue of pending MDU writebacks (rd + data).
// Entry rd values and valids are exposed for hazard lookup.
module wb_skid_fifo
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
)(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_push,
  input  logic [REG_ADDR_W-1:0]       i_rd,
  input  logic [DATA_WIDTH-1:0]       i_data,
  input  logic                        i_pop,
  output logic [1:0]                  o_count,
  output logic [REG_ADDR_W-1:0]       o_head_rd,
  output logic [DATA_WIDTH-1:0]       o_head_data,
  output logic [1:0]                  o_ent_vld,
  output logic [1:0][REG_ADDR_W-1:0]  o_ent_rd
);

  logic [1:0][REG_ADDR_W-1:0] r_rd;
  logic [1:0][DATA_WIDTH-1:0] r_data;
  logic                       r_wptr;
  logic                       r_rptr;
  logic [1:0]                 r_count;

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_rd[r_wptr]   <= i_rd;
      r_data[r_wptr] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (i_push) r_wptr <= ~r_wptr;
      if (i_pop)  r_rptr <= ~r_rptr;
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count     = r_count;
  assign o_head_rd   = r_rd[r_rptr];
  assign o_head_data = r_data[r_rptr];
  assign o_ent_rd    = r_rd;

  always_comb begin
    o_ent_vld = 2'b00;
    unique case (1'b1)
      (r_count == FIFO_DEPTH): o_ent_vld = 2'b11;
      (r_count == 2'd1):       o_ent_vld = 2'b01 << r_rptr;
      default:                 o_ent_vld = 2'b00;
    endcase
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Single register-file write port shared by the W stage and the MDU.
// Pipeline wins unless the queued MDU head has aged to the starve limit.
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int STARVE_LIMIT = 4
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWriteW,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic [DATA_WIDTH-1:0] ResultW,
  input  logic                  MduValid,
  input  logic [REG_ADDR_W-1:0] MduRd,
  input  logic [DATA_WIDTH-1:0] MduResult,
  output logic                  MduReady,
  output logic                  StallW,
  output logic                  RegWriteEn,
  output logic [REG_ADDR_W-1:0] RegWrAddr,
  output logic [DATA_WIDTH-1:0] RegWrData,
  input  logic [REG_ADDR_W-1:0] QueryRd,
  output logic                  QueryHit
);

  localparam logic [AGE_W-1:0] L_LIMIT = AGE_W'(STARVE_LIMIT);

  logic                       w_p;
  logic                       w_h;
  logic                       w_gnt_mdu;
  logic                       w_gnt_p;
  logic                       w_push;
  logic [1:0]                 w_count;
  logic [REG_ADDR_W-1:0]      w_head_rd;
  logic [DATA_WIDTH-1:0]      w_head_data;
  logic [1:0]                 w_ent_vld;
  logic [1:0][REG_ADDR_W-1:0] w_ent_rd;
  logic [AGE_W-1:0]           r_age;

  assign w_p       = RegWriteW && (RdW != REG_X0);
  assign w_h       = (w_count != 2'd0);
  assign w_gnt_mdu = w_h && (!w_p || (r_age >= L_LIMIT));
  assign w_gnt_p   = w_p && !w_gnt_mdu;
  assign MduReady  = (w_count < FIFO_DEPTH);
  assign w_push    = MduValid && MduReady && (MduRd != REG_X0);
  assign StallW    = w_p && w_gnt_mdu;

  wb_skid_fifo #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_rd        (MduRd),
    .i_data      (MduResult),
    .i_pop       (w_gnt_mdu),
    .o_count     (w_count),
    .o_head_rd   (w_head_rd),
    .o_head_data (w_head_data),
    .o_ent_vld   (w_ent_vld),
    .o_ent_rd    (w_ent_rd)
  );

  // Age tracks how long the current head has been passed over.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_age <= '0;
    end else if (w_gnt_mdu || !w_h) begin
      r_age <= '0;
    end else if (r_age != AGE_MAX) begin
      r_age <= r_age + 1'b1;
    end
  end

  always_comb begin
    RegWriteEn = 1'b0;
    RegWrAddr  = REG_X0;
    RegWrData  = '0;
    unique case (1'b1)
      w_gnt_mdu: begin
        RegWriteEn = 1'b1;
        RegWrAddr  = w_head_rd;
        RegWrData  = w_head_data;
      end
      w_gnt_p: begin
        RegWriteEn = 1'b1;
        RegWrAddr  = RdW;
        RegWrData  = ResultW;
      end
      default: ;
    endcase
  end

  always_comb begin
    QueryHit = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (w_ent_vld[i] && (w_ent_rd[i] == QueryRd) && (QueryRd != REG_X0))
        QueryHit = 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench: queue-based reference model plus directed
// literal scenarios, then randomized traffic with occasional reset.
module tb_regfile_wr_arbiter;
  localparam int DW  = 32;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          RegWriteW;
  logic [4:0]    RdW;
  logic [DW-1:0] ResultW;
  logic          MduValid;
  logic [4:0]    MduRd;
  logic [DW-1:0] MduResult;
  logic          MduReady;
  logic          StallW;
  logic          RegWriteEn;
  logic [4:0]    RegWrAddr;
  logic [DW-1:0] RegWrData;
  logic [4:0]    QueryRd;
  logic          QueryHit;

  regfile_wr_arbiter #(
    .DATA_WIDTH   (DW),
    .STARVE_LIMIT (LIM)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .RegWriteW  (RegWriteW),
    .RdW        (RdW),
    .ResultW    (ResultW),
    .MduValid   (MduValid),
    .MduRd      (MduRd),
    .MduResult  (MduResult),
    .MduReady   (MduReady),
    .StallW     (StallW),
    .RegWriteEn (RegWriteEn),
    .RegWrAddr  (RegWrAddr),
    .RegWrData  (RegWrData),
    .QueryRd    (QueryRd),
    .QueryHit   (QueryHit)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]    rd;
    logic [DW-1:0] d;
  } ent_t;

  ent_t q[$];
  int   age;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic          e_mdu, e_en, e_stall, e_ready, e_hit;
  logic [4:0]    e_addr;
  logic [DW-1:0] e_data;
  logic [4:0]    stall_addrs[$];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: pending results live in a queue, oldest first.
  task automatic model_eval();
    bit p;
    p = RegWriteW && (RdW != 5'd0);
    if (rst) begin
      q.delete();
      age = 0;
    end
    e_mdu   = (q.size() > 0) && (!p || age >= LIM);
    e_stall = p && e_mdu;
    e_ready = (q.size() < 2);
    e_en    = e_mdu || p;
    e_addr  = 5'd0;
    e_data  = '0;
    if (e_mdu) begin
      e_addr = q[0].rd;
      e_data = q[0].d;
    end else if (p) begin
      e_addr = RdW;
      e_data = ResultW;
    end
    e_hit = 1'b0;
    foreach (q[i])
      if (QueryRd != 5'd0 && q[i].rd == QueryRd) e_hit = 1'b1;
  endtask

  task automatic model_commit();
    bit was_empty;
    ent_t e;
    if (!rst) begin
      was_empty = (q.size() == 0);
      if (e_mdu) void'(q.pop_front());
      if (e_mdu || was_empty) age = 0;
      else if (age < 15) age = age + 1;
      if (MduValid && e_ready && MduRd != 5'd0) begin
        e.rd = MduRd;
        e.d  = MduResult;
        q.push_back(e);
      end
    end
  endtask

  task automatic compare();
    model_eval();
    chk("MduReady",   MduReady,   e_ready);
    chk("StallW",     StallW,     e_stall);
    chk("RegWriteEn", RegWriteEn, e_en);
    chk("RegWrAddr",  RegWrAddr,  e_addr);
    chk("RegWrData",  RegWrData,  e_data);
    chk("QueryHit",   QueryHit,   e_hit);
    if (StallW) stall_addrs.push_back(RegWrAddr);
  endtask

  task automatic cyc();
    #1;
    compare();
    #1;
  endtask

  task automatic edge_();
    @(posedge clk);
    model_eval();
    model_commit();
    @(negedge clk);
  endtask

  task automatic tick();
    cyc();
    edge_();
  endtask

  task automatic drive(input logic w, input logic [4:0] rd,
                       input logic [DW-1:0] res, input logic mv,
                       input logic [4:0] mrd, input logic [DW-1:0] mres,
                       input logic [4:0] qr);
    RegWriteW = w;
    RdW       = rd;
    ResultW   = res;
    MduValid  = mv;
    MduRd     = mrd;
    MduResult = mres;
    QueryRd   = qr;
  endtask

  initial begin
    bit acc;
    bit done;
    rst = 1'b1;
    age = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    // Reset state, pipeline pass-through during reset
    cyc();
    chk("rst_ready", MduReady, 1);
    chk("rst_en", RegWriteEn, 0);
    edge_();
    drive(1, 4, 32'h44, 0, 0, 0, 0);
    cyc();
    chk("rst_pass_en", RegWriteEn, 1);
    chk("rst_pass_addr", RegWrAddr, 4);
    chk("rst_stall", StallW, 0);
    edge_();
    rst = 1'b0;

    // Idle pipeline, MDU result written the next cycle
    drive(0, 0, 0, 1, 5, 32'hAAAA0001, 0);
    cyc();
    chk("s1_ready", MduReady, 1);
    chk("s1_en0", RegWriteEn, 0);
    edge_();
    drive(0, 0, 0, 0, 0, 0, 0);
    cyc();
    chk("s1_en", RegWriteEn, 1);
    chk("s1_addr", RegWrAddr, 5);
    chk("s1_data", RegWrData, 32'hAAAA0001);
    chk("s1_stall", StallW, 0);
    edge_();

    // Starvation: pipeline wins four cycles, then MDU forces a stall
    drive(1, 3, 32'h33, 1, 7, 32'h77, 0);
    cyc();
    chk("s2_first", RegWrAddr, 3);
    edge_();
    MduValid = 0;
    for (int i = 0; i < LIM; i++) begin
      cyc();
      chk("s2_pipe", RegWrAddr, 3);
      chk("s2_nostall", StallW, 0);
      edge_();
    end
    cyc();
    chk("s2_mdu_addr", RegWrAddr, 7);
    chk("s2_mdu_data", RegWrData, 32'h77);
    chk("s2_stall", StallW, 1);
    edge_();
    cyc();
    chk("s2_resume", RegWrAddr, 3);
    chk("s2_resume_st", StallW, 0);
    edge_();

    // x0 pipeline write, query hit, MduRd=0 handshake
    drive(0, 0, 0, 1, 9, 32'h99, 9);
    tick();
    drive(1, 0, 32'h1, 0, 0, 0, 9);
    cyc();
    chk("s3_hit", QueryHit, 1);
    chk("s3_addr", RegWrAddr, 9);
    chk("s3_stall", StallW, 0);
    edge_();
    drive(0, 0, 0, 1, 0, 32'h5, 9);
    cyc();
    chk("s3_hit_gone", QueryHit, 0);
    chk("s3_x0_ready", MduReady, 1);
    edge_();
    drive(0, 0, 0, 0, 0, 0, 0);
    cyc();
    chk("s3_x0_noenq", RegWriteEn, 0);
    chk("s3_q0", QueryHit, 0);
    edge_();

    // Full FIFO backpressure, order preserved
    stall_addrs.delete();
    drive(1, 3, 32'h33, 1, 12, 32'hC, 0);
    tick();
    drive(1, 3, 32'h33, 1, 13, 32'hD, 0);
    tick();
    drive(1, 3, 32'h33, 1, 14, 32'hE, 0);
    cyc();
    chk("s4_full", MduReady, 0);
    edge_();
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      cyc();
      acc = MduReady;
      edge_();
      if (acc) begin
        MduValid = 0;
        done = 1;
      end
    end
    chk("s4_accepted", done, 1);
    for (int i = 0; i < 20; i++) tick();
    chk("s4_n", stall_addrs.size(), 3);
    if (stall_addrs.size() == 3) begin
      chk("s4_o0", stall_addrs[0], 12);
      chk("s4_o1", stall_addrs[1], 13);
      chk("s4_o2", stall_addrs[2], 14);
    end

    // Reset mid-flight with count 2, age 3
    drive(1, 3, 32'h33, 1, 12, 32'hC, 12);
    tick();
    drive(1, 3, 32'h33, 1, 13, 32'hD, 12);
    tick();
    MduValid = 0;
    tick();
    tick();
    cyc();
    chk("s5_full", MduReady, 0);
    chk("s5_hit", QueryHit, 1);
    chk("s5_age3", age, 3);
    rst = 1'b1;
    #1;
    compare();
    chk("s5_rst_ready", MduReady, 1);
    chk("s5_rst_hit", QueryHit, 0);
    chk("s5_rst_stall", StallW, 0);
    chk("s5_rst_addr", RegWrAddr, 3);
    edge_();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 12);
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("s5_no_mdu", RegWriteEn, 0);
      edge_();
    end

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      RegWriteW = ($urandom_range(0, 3) != 0);
      RdW       = 5'($urandom_range(0, 7));
      ResultW   = $urandom;
      MduValid  = ($urandom_range(0, 2) == 0);
      MduRd     = 5'($urandom_range(0, 7));
      MduResult = $urandom;
      QueryRd   = 5'($urandom_range(0, 7));
      rst       = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
